// File: rtl/adc_capture_log.sv
// Pre/post-trigger capture of 48-bit ADC sample words into a ring buffer, then a byte-serial dump.
// Latency: rd_valid rises 2 cycles after READOUT entry, then 1 byte/cycle; the buffer read is 1 cycle.
// Backpressure: rd_valid/rd_ready handshake; rd_data holds while stalled; strobes outside capture are dropped.
module adc_capture_log #(
  parameter int DEPTH       = 256,
  parameter int PRE_SAMPLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] ad_a0,
  input  logic [11:0] ad_a1,
  input  logic [11:0] ad_b0,
  input  logic [11:0] ad_b1,
  input  logic        ad_strobe,
  input  logic        start,
  input  logic        trigger,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [2:0]  state,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   PRE_L    = (AW+1)'(PRE_SAMPLES);
  localparam logic [AW:0]   POST_L   = (AW+1)'(DEPTH - PRE_SAMPLES);
  localparam logic [AW-1:0] PRE_AW   = AW'(PRE_SAMPLES);
  localparam logic [AW-1:0] LAST_SMP = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [47:0]   r_mem [DEPTH];
  logic [47:0]   r_ram_q;
  logic [47:0]   r_word;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_trig_ptr;
  logic [AW-1:0] r_pre_cnt;
  logic [AW-1:0] r_post_cnt;
  logic [AW-1:0] r_smp_cnt;
  logic [2:0]    r_byte_idx;
  logic          r_rd_valid;
  logic          r_ram_ok;
  logic          r_done;

  logic [47:0]   w_sample;
  logic          w_capture;
  logic          w_wr_en;
  logic          w_accept;
  logic          w_last_byte;
  logic          w_last_smp;
  logic          w_pre_hit;
  logic          w_post_hit;
  logic          w_enter_rd;
  logic [AW-1:0] w_trig_src;

  assign w_sample    = {ad_a0, ad_a1, ad_b0, ad_b1};
  assign w_capture   = (r_state == S_FILL) || (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr_en     = w_capture && ad_strobe && !reset;
  // rd_valid is only ever high in READOUT, so the handshake needs no state qualifier.
  assign w_accept    = r_rd_valid && rd_ready;
  assign w_last_byte = (r_byte_idx == 3'd5);
  assign w_last_smp  = (r_smp_cnt == LAST_SMP);
  assign w_pre_hit   = (({1'b0, r_pre_cnt} + (AW+1)'(1)) == PRE_L);
  assign w_post_hit  = (({1'b0, r_post_cnt} + (AW+1)'(1)) == POST_L);
  assign w_enter_rd  = (w_next_state == S_READOUT) && (r_state != S_READOUT);
  // When ARMED jumps straight to READOUT, trig_ptr has not been latched yet.
  assign w_trig_src  = (r_state == S_ARMED) ? r_wr_ptr : r_trig_ptr;

  assign state    = r_state;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

  // Next-state decode; unused encodings fall back to IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_FILL;
      S_FILL:         if (ad_strobe && w_pre_hit) w_next_state = S_ARMED;
      S_ARMED:        if (trigger) w_next_state = (ad_strobe && (POST_L == (AW+1)'(1))) ? S_READOUT : S_POST;
      S_POST:         if (ad_strobe && w_post_hit) w_next_state = S_READOUT;
      S_READOUT:      if (w_accept && w_last_byte && w_last_smp) w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
  end

  // State register and registered done flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Pointers, counters and the readout byte engine.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_trig_ptr <= '0;
      r_pre_cnt  <= '0;
      r_post_cnt <= '0;
      r_smp_cnt  <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_rd_valid <= 1'b0;
      r_ram_ok   <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
          end
        end
        S_FILL: begin
          if (ad_strobe) r_pre_cnt <= r_pre_cnt + AW'(1);
        end
        S_ARMED: begin
          if (trigger) begin
            r_trig_ptr <= r_wr_ptr;
            r_post_cnt <= ad_strobe ? AW'(1) : '0;
          end
        end
        S_POST: begin
          if (ad_strobe) r_post_cnt <= r_post_cnt + AW'(1);
        end
        S_READOUT: begin
          // r_ram_q tracks r_rd_ptr one cycle late; the first load waits for it to settle.
          r_ram_ok <= 1'b1;
          if (!r_rd_valid) begin
            if (r_ram_ok) begin
              r_word     <= r_ram_q;
              r_rd_valid <= 1'b1;
              r_rd_ptr   <= r_rd_ptr + AW'(1);
            end
          end else if (w_accept) begin
            if (w_last_byte) begin
              r_byte_idx <= '0;
              if (w_last_smp) begin
                r_rd_valid <= 1'b0;
              end else begin
                // Next word was fetched during the previous six byte cycles.
                r_smp_cnt <= r_smp_cnt + AW'(1);
                r_word    <= r_ram_q;
                r_rd_ptr  <= r_rd_ptr + AW'(1);
              end
            end else begin
              r_byte_idx <= r_byte_idx + 3'd1;
            end
          end
        end
        default: ;
      endcase
      if (w_enter_rd) begin
        r_rd_ptr   <= w_trig_src - PRE_AW;
        r_smp_cnt  <= '0;
        r_byte_idx <= '0;
        r_ram_ok   <= 1'b0;
        r_rd_valid <= 1'b0;
      end
    end
  end

  // Sample buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_sample;
  end

  // Registered buffer read at the readout pointer.
  always_ff @(posedge clk) begin
    r_ram_q <= r_mem[r_rd_ptr];
  end

  // Byte select, most significant byte first.
  always_comb begin
    rd_data = r_word[7:0];
    case (r_byte_idx)
      3'd0:    rd_data = r_word[47:40];
      3'd1:    rd_data = r_word[39:32];
      3'd2:    rd_data = r_word[31:24];
      3'd3:    rd_data = r_word[23:16];
      3'd4:    rd_data = r_word[15:8];
      default: rd_data = r_word[7:0];
    endcase
  end

endmodule

// File: tb/tb_adc_capture_log.sv
// Bench for adc_capture_log with DEPTH=16, PRE_SAMPLES=4 and a strobe every 16 cycles.
// Expected readout is the run of presented samples from (trigger sample - PRE) onward.
// Ready patterns: always high, 1-0-0-1, and random with start/trigger noise.
module tb_adc_capture_log;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int NBYTES = 6 * DEPTH;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
  logic        ad_strobe, start, trigger, rd_ready;
  logic [7:0]  rd_data;
  logic        rd_valid, done;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n = 0;
  logic [47:0] pres [256];

  always #5 clk = ~clk;

  adc_capture_log #(.DEPTH(DEPTH), .PRE_SAMPLES(PRE)) dut (
    .clk(clk), .reset(reset),
    .ad_a0(ad_a0), .ad_a1(ad_a1), .ad_b0(ad_b0), .ad_b1(ad_b1),
    .ad_strobe(ad_strobe), .start(start), .trigger(trigger),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .state(state), .done(done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit strobe_due();
    return (cyc % 16) == 15;
  endfunction

  // One clock: present a sample on strobe cycles, then sample outputs 1 time unit after the edge.
  task automatic step();
    ad_strobe = strobe_due();
    if (ad_strobe) {ad_a0, ad_a1, ad_b0, ad_b1} = pres[n % 256];
    @(posedge clk);
    #1;
    if (ad_strobe) n++;
    cyc++;
    ad_strobe = 1'b0;
  endtask

  task automatic fill_pattern(input bit rnd);
    logic [63:0] t;
    for (int i = 0; i < 256; i++) begin
      if (rnd) begin
        t = {$urandom(), $urandom()};
        pres[i] = t[47:0];
      end else begin
        pres[i] = {12'(i), 12'(256 + i), 12'(512 + i), 12'(768 + i)};
      end
    end
  endtask

  // rmode: 0 ready always high, 1 ready 1-0-0-1, 2 random ready with start/trigger noise.
  // rst_at >= 0 pulses reset once that many bytes have been accepted.
  task automatic run_capture(input string tag, input int trig_n, input bit same_cycle,
                             input bit hold, input int rmode, input int rst_at);
    int k;
    int nb;
    int lat;
    bit pstall;
    logic [7:0] pdat;
    logic [47:0] w;
    logic [7:0] eb;
    start = 1'b1;
    trigger = hold;
    step();
    start = 1'b0;
    n = 0;
    if (hold) begin
      k = 0;
      while (n < PRE && k < 2000) begin step(); k++; end
      check({tag, "_armed"}, state, 64'd2);
      step();
      check({tag, "_post"}, state, 64'd3);
      trigger = 1'b0;
    end else begin
      k = 0;
      while (!(n == trig_n && strobe_due() == same_cycle) && k < 2000) begin step(); k++; end
      trigger = 1'b1;
      step();
      trigger = 1'b0;
    end
    k = 0;
    while (state != 3'd4 && k < 2000) begin step(); k++; end
    check({tag, "_reach_readout"}, state, 64'd4);
    if (state != 3'd4) return;

    k = 0; nb = 0; lat = -1; pstall = 1'b0; pdat = '0;
    while (nb < NBYTES && k < 3000) begin
      if (lat < 0 && rd_valid) lat = k;
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = (k % 4 == 0) || (k % 4 == 3);
        default: begin
          rd_ready = 1'($urandom_range(0, 1));
          start    = ($urandom_range(0, 7) == 0);
          trigger  = ($urandom_range(0, 7) == 0);
        end
      endcase
      if (pstall) begin
        check({tag, "_stall_valid"}, rd_valid, 64'd1);
        check({tag, "_stall_data"}, rd_data, pdat);
      end
      if (rst_at >= 0 && nb == rst_at) begin
        reset = 1'b1; start = 1'b1; trigger = 1'b1; rd_ready = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; trigger = 1'b0;
        check({tag, "_rst_state"}, state, 64'd0);
        check({tag, "_rst_valid"}, rd_valid, 64'd0);
        check({tag, "_rst_done"}, done, 64'd0);
        check({tag, "_rst_data"}, rd_data, 64'd0);
        return;
      end
      if (rd_valid && rd_ready) begin
        w  = pres[(trig_n - PRE + nb / 6) % 256];
        eb = w[8 * (5 - nb % 6) +: 8];
        check({tag, "_byte"}, rd_data, eb);
        nb++;
      end
      pstall = rd_valid && !rd_ready;
      pdat   = rd_data;
      step();
      k++;
    end
    start = 1'b0;
    trigger = 1'b0;
    check({tag, "_first_valid_latency_ok"}, (lat >= 0 && lat <= 3), 64'd1);
    check({tag, "_byte_count"}, nb, NBYTES);
    if (rmode == 0) check({tag, "_no_bubbles"}, k - lat, NBYTES);
    check({tag, "_done_state"}, state, 64'd5);
    check({tag, "_done_flag"}, done, 64'd1);
    check({tag, "_done_valid"}, rd_valid, 64'd0);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check({tag, "_done_hold"}, {state, done, rd_valid}, {3'd5, 1'b1, 1'b0});
    rd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; trigger = 1'b0; rd_ready = 1'b0; ad_strobe = 1'b0;
    {ad_a0, ad_a1, ad_b0, ad_b1} = '0;
    fill_pattern(1'b0);
    for (int i = 0; i < 3; i++) step();
    reset = 1'b0;
    check("reset_state", state, 64'd0);
    check("reset_done", done, 64'd0);
    check("reset_valid", rd_valid, 64'd0);
    check("reset_data", rd_data, 64'd0);

    // Trigger and rd_ready are meaningless in IDLE.
    trigger = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check("idle_ignore", {state, rd_valid}, {3'd0, 1'b0});
    trigger = 1'b0; rd_ready = 1'b0;

    run_capture("basic", 10, 1'b1, 1'b0, 0, -1);
    run_capture("between", 7, 1'b0, 1'b0, 0, -1);
    run_capture("hold", PRE, 1'b0, 1'b1, 0, -1);
    run_capture("wrap", 40, 1'b0, 1'b0, 0, -1);
    run_capture("toggle", 12, 1'b0, 1'b0, 1, -1);
    run_capture("midrst", 9, 1'b0, 1'b0, 0, 50);
    run_capture("after_rst", 10, 1'b1, 1'b0, 0, -1);

    fill_pattern(1'b1);
    for (int r = 0; r < 3; r++)
      run_capture("rand", $urandom_range(PRE, 30), 1'($urandom_range(0, 1)), 1'b0, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
